input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable cycles needed to accept a button level change; legal range is 2 to 2^24.
REQ-002 Parameter BTN_ACTIVE_LOW, default 1; when 1, a raw button at 0 means pressed.
REQ-003 clk  input  1  is the single system clock.
REQ-004 reset  input  1  is the asynchronous, active-high reset.
REQ-005 btn0_raw  input  1  is the unsynchronised confirm button.
REQ-006 btn1_raw  input  1  is the unsynchronised back/undo button.
REQ-007 sw_raw  input  10  is the unsynchronised digit switches; bit i selects digit i.
REQ-008 p0_pulse  output  1  is a one-cycle pulse per accepted press of btn0.
REQ-009 p1_pulse  output  1  is a one-cycle pulse per accepted press of btn1.
REQ-010 sw_val  output  4  is the index of the single active switch (0-9).
REQ-011 sw_valid  output  1  is 1 when exactly one switch is on.
REQ-012 lfsr_val  output  4  is a pseudo-random digit, always in the range 0-9.

Function
REQ-013 Each raw input (btn0, btn1, all 10 sw bits) shall pass through a two-flop synchroniser before any other logic sees it.
REQ-014 Each button shall have a debounced state register (0 = released) and a counter of width clog2(DEBOUNCE_CYCLES+1).
- Counter clears to 0 in any cycle where the synchronised pressed-level equals the debounced state.
- Otherwise the counter increments.
REQ-015 When the counter reaches DEBOUNCE_CYCLES-1 and the input still differs, the debounced state shall toggle on that edge and the counter shall clear.
REQ-016 p0_pulse/p1_pulse shall be registered and go high for exactly one cycle, in the cycle after the debounced state changes from released to pressed.
- Release transitions produce no pulse.
REQ-017 Latency: with a clean press, the pulse goes high DEBOUNCE_CYCLES+3 edges after the first edge that samples the pressed raw level.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synchronised cycles shall produce no pulse and shall leave the debounced state unchanged.
REQ-019 Holding a button shall produce one pulse only.
- A new pulse requires an accepted release and then an accepted press.
REQ-020 The two buttons are independent.
- Simultaneous accepted presses assert p0_pulse and p1_pulse in the same cycle.
- No priority is applied here; arbitration belongs to the consumer.
REQ-021 Switch decode shall be registered from the synchronised switches (3-edge latency from raw).
- Exactly one bit i set: sw_valid=1, sw_val=i.
- Zero bits or two or more bits set: sw_valid=0, sw_val=0.
REQ-022 An 8-bit Fibonacci LFSR (taps 8,6,5,4; shift left, feedback into bit 0) shall advance every clock cycle.
- It shall never reach 8'h00.
REQ-023 lfsr_val shall be registered from the current LFSR low nibble n.
- n<=9: lfsr_val=n.
- n>=10: lfsr_val=n-6.
REQ-024 All outputs shall be driven from registers, with no combinational path from any raw input to any output.

Reset
REQ-025 Reset shall act asynchronously, with the following values held while reset is high:
- Synchronisers at the released level, debounced states released, counters 0.
- p0_pulse=0, p1_pulse=0, sw_val=0, sw_valid=0.
- LFSR=8'h01, lfsr_val=1.
REQ-026 A button held pressed through reset deassertion shall be treated as a new press.
- It pulses once after DEBOUNCE_CYCLES+3 edges.
REQ-027 Reset asserted during a debounce count shall abort the count, and no pulse shall follow from the pre-reset activity.

Verification (DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1)
REQ-028 btn0_raw held 0 for 20 cycles -> p0_pulse high exactly once, 7 edges after the first low sample; p1_pulse stays 0.
REQ-029 btn1_raw low for 3 cycles then high -> no p1_pulse; debounced state stays released.
REQ-030 btn0_raw and btn1_raw driven low on the same edge -> both pulses high in the same cycle.
REQ-031 sw_raw=10'h008 -> after 3 edges sw_val=3, sw_valid=1; sw_raw=10'h009 -> sw_valid=0, sw_val=0; sw_raw=0 -> sw_valid=0.
REQ-032 Release reset and run 255 cycles -> LFSR returns to 8'h01 (maximal period), never 0; lfsr_val stays within 0-9 and matches the nibble map every cycle.
REQ-033 Assert reset 2 cycles into a btn0 debounce, then release with btn0 held low -> exactly one p0_pulse, 7 edges after reset deasserts.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises, debounces and edge-detects two buttons, decodes one-hot
// digit switches and produces a pseudo-random digit from an 8-bit LFSR.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn0_raw,
    input  logic       btn1_raw,
    input  logic [9:0] sw_raw,
    output logic       p0_pulse,
    output logic       p1_pulse,
    output logic [3:0] sw_val,
    output logic       sw_valid,
    output logic [3:0] lfsr_val
);
    localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic            REL      = BTN_ACTIVE_LOW;

    logic [1:0]    btn_s1, btn_s2, pressed, db_state, db_prev;
    logic [CW-1:0] cnt [2];
    logic [9:0]    sw_s1, sw_s2;
    logic [3:0]    sw_idx;
    logic          sw_one;
    logic [7:0]    lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1 <= {2{REL}};
            btn_s2 <= {2{REL}};
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= {btn1_raw, btn0_raw};
            btn_s2 <= btn_s1;
            sw_s1  <= sw_raw;
            sw_s2  <= sw_s1;
        end
    end

    assign pressed = btn_s2 ^ {2{REL}};

    // Debounced state flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_state <= '0;
            db_prev  <= '0;
            cnt      <= '{default: '0};
            p0_pulse <= 1'b0;
            p1_pulse <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pressed[i] == db_state[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db_state[i] <= ~db_state[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            db_prev  <= db_state;
            p0_pulse <= db_state[0] & ~db_prev[0];
            p1_pulse <= db_state[1] & ~db_prev[1];
        end
    end

    always_comb begin
        sw_idx = '0;
        for (int i = 0; i < 10; i++)
            if (sw_s2[i]) sw_idx = 4'(i);
    end

    assign sw_one = $onehot(sw_s2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_val   <= '0;
            sw_valid <= 1'b0;
        end else begin
            sw_val   <= sw_one ? sw_idx : 4'd0;
            sw_valid <= sw_one;
        end
    end

    // Taps 8,6,5,4 give a maximal 255-state sequence that never reaches zero from a nonzero seed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr     <= 8'h01;
            lfsr_val <= 4'd1;
        end else begin
            lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            lfsr_val <= (lfsr[3:0] > 4'd9) ? lfsr[3:0] - 4'd6 : lfsr[3:0];
        end
    end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: table vectors, directed button sequences and a randomized
// windowed debounce model for input_conditioner with DEBOUNCE_CYCLES=4, active-low buttons.
module tb_input_conditioner;
    localparam int D = 4;
    localparam int NR = 1500;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn0_raw = 1'b1;
    logic       btn1_raw = 1'b1;
    logic [9:0] sw_raw = '0;
    logic       p0_pulse, p1_pulse, sw_valid;
    logic [3:0] sw_val, lfsr_val;

    int n_cmp = 0;
    int n_bad = 0;

    input_conditioner #(.DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .btn0_raw(btn0_raw), .btn1_raw(btn1_raw), .sw_raw(sw_raw),
        .p0_pulse(p0_pulse), .p1_pulse(p1_pulse), .sw_val(sw_val), .sw_valid(sw_valid),
        .lfsr_val(lfsr_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] sw;
        logic [3:0] val;
        logic       valid;
    } sw_vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn0_raw = 1'b1;
        btn1_raw = 1'b1;
        sw_raw   = '0;
        reset    = 1'b1;
        step();
        step();
        check("rst_p0", p0_pulse, 0);
        check("rst_p1", p1_pulse, 0);
        check("rst_sw_val", sw_val, 0);
        check("rst_sw_valid", sw_valid, 0);
        check("rst_lfsr_val", lfsr_val, 1);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    function automatic int digit_of(input int l);
        int n;
        n = l % 16;
        return (n <= 9) ? n : n - 6;
    endfunction

    function automatic int lfsr_next(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) | fb) & 255;
    endfunction

    // Press is accepted at edge t when the synchronised level (raw from edge t-2)
    // has disagreed with the debounced state for the last D edges.
    bit hist [2][NR+1];
    bit st [2];
    bit press_prev [2];

    initial begin
        sw_vec_t tbl [8];
        bit exp_p [2];
        int l, run0, run1, prev_val, prev_valid;
        bit lv0, lv1, all_diff, seen;
        tbl[0] = '{10'h008, 4'd3, 1'b1};
        tbl[1] = '{10'h009, 4'd0, 1'b0};
        tbl[2] = '{10'h000, 4'd0, 1'b0};
        tbl[3] = '{10'h001, 4'd0, 1'b1};
        tbl[4] = '{10'h200, 4'd9, 1'b1};
        tbl[5] = '{10'h3FF, 4'd0, 1'b0};
        tbl[6] = '{10'h100, 4'd8, 1'b1};
        tbl[7] = '{10'h020, 4'd5, 1'b1};

        do_reset();
        btn0_raw = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("hold_p0", p0_pulse, int'(k == D + 3));
            check("hold_p1", p1_pulse, 0);
        end
        btn0_raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("release_no_pulse", p0_pulse, 0);
        end

        btn1_raw = 1'b0;
        idle(3);
        btn1_raw = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            check("glitch_p1", p1_pulse, 0);
        end
        btn1_raw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("after_glitch_p1", p1_pulse, int'(k == D + 3));
        end
        btn1_raw = 1'b1;
        idle(10);

        btn0_raw = 1'b0;
        btn1_raw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("both_p0", p0_pulse, int'(k == D + 3));
            check("both_p1", p1_pulse, int'(k == D + 3));
        end
        btn0_raw = 1'b1;
        btn1_raw = 1'b1;
        idle(10);

        prev_val = 0;
        prev_valid = 0;
        foreach (tbl[i]) begin
            sw_raw = tbl[i].sw;
            step();
            step();
            check("sw_val_latency", sw_val, prev_val);
            check("sw_valid_latency", sw_valid, prev_valid);
            step();
            check("sw_val_tbl", sw_val, tbl[i].val);
            check("sw_valid_tbl", sw_valid, tbl[i].valid);
            prev_val = tbl[i].val;
            prev_valid = tbl[i].valid;
        end
        for (int i = 0; i < 40; i++) begin
            sw_raw = ($urandom_range(1) == 1) ? 10'(1 << $urandom_range(9)) : 10'($urandom);
            idle(3);
            check("sw_valid_rand", sw_valid, int'($countones(sw_raw) == 1));
            check("sw_val_rand", sw_val, ($countones(sw_raw) == 1) ? $clog2(sw_raw) : 0);
        end
        sw_raw = '0;

        btn0_raw = 1'b0;
        idle(4);
        reset = 1'b1;
        step();
        check("mid_rst_p0", p0_pulse, 0);
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("post_rst_p0", p0_pulse, int'(k == D + 3));
        end
        btn0_raw = 1'b1;
        idle(10);
        btn0_raw = 1'b0;
        idle(4);
        reset = 1'b1;
        btn0_raw = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            check("abort_p0", p0_pulse, 0);
        end

        do_reset();
        l = 1;
        for (int k = 1; k <= 300; k++) begin
            step();
            check("lfsr_val", lfsr_val, digit_of(l));
            check("lfsr_range", int'(lfsr_val <= 4'd9), 1);
            l = lfsr_next(l);
        end

        do_reset();
        st = '{0, 0};
        press_prev = '{0, 0};
        lv0 = 1'b0;
        lv1 = 1'b0;
        run0 = 0;
        run1 = 0;
        for (int t = 1; t <= NR; t++) begin
            if (run0 == 0) begin
                lv0 = ($urandom_range(1) == 1);
                run0 = $urandom_range(1, 8);
            end
            if (run1 == 0) begin
                lv1 = ($urandom_range(1) == 1);
                run1 = $urandom_range(1, 8);
            end
            run0--;
            run1--;
            btn0_raw = ~lv0;
            btn1_raw = ~lv1;
            hist[0][t] = lv0;
            hist[1][t] = lv1;
            step();
            for (int b = 0; b < 2; b++) begin
                all_diff = 1'b1;
                for (int u = t - D + 1; u <= t; u++) begin
                    seen = (u - 2 >= 1) ? hist[b][u-2] : 1'b0;
                    if (seen == st[b]) all_diff = 1'b0;
                end
                exp_p[b] = press_prev[b];
                press_prev[b] = all_diff && !st[b];
                if (all_diff) st[b] = !st[b];
            end
            check("rand_p0", p0_pulse, exp_p[0]);
            check("rand_p1", p1_pulse, exp_p[1]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
